mem_bus_responder: RTL and testbench
====================================

Name: mem_bus_responder

Overview:
- Memory-side responder for the cpu_core memory bus.
- Accepts one read or write request at a time from the core's address/data outputs.
- Holds a word-organised RAM and returns read data on the core's data input, with a one-cycle bus_full strobe after a fixed latency.
- Replaces hand-driven bus stimulus in core-level benches and is the bus endpoint in the integrated design.

Parameters:
- DEPTH, 256, number of 32-bit words in the RAM (power of two, at least 4).
- LATENCY, 2, cycles from the accepting edge to the edge that raises bus_full (at least 1).
- BASE_ADDR, 32'h0000_0000, byte address of word 0.

Ports:
- clk  in  1  system clock, rising-edge.
- rst  in  1  reset, asynchronous, active-high.
- address_in  in  32  byte address from the core's address_out.
- data_in  in  32  write data from the core's data_out_BUS.
- read_en  in  1  read request, sampled at posedge.
- write_en  in  1  write request, sampled at posedge.
- sel  in  4  byte enables for writes; bit i covers data bits [8i+7:8i].
- data_out  out  32  read data to the core's data_in_BUS.
- bus_full  out  1  one-cycle response strobe, for reads and writes.
- busy  out  1  high while a request is in flight.
- err  out  1  one-cycle error strobe, coincident with bus_full.

Behaviour:
- Reset (async, rst=1):
  - FSM goes to IDLE.
  - data_out=0, bus_full=0, busy=0, err=0, latency counter=0.
  - RAM contents are not cleared.
  - Reset during BUSY aborts the request: no write is committed and no bus_full is issued.
- States: IDLE, BUSY, RESPOND.
- IDLE:
  - At a posedge with read_en or write_en high, latch address_in, data_in, sel and op.
  - If both enables are high, write wins and err is flagged for the response.
  - Load counter with LATENCY-1 and go to BUSY. busy rises on the same edge.
- BUSY:
  - Counter decrements each cycle.
  - When counter==0, the next edge goes to RESPOND.
  - With LATENCY=1, BUSY lasts one cycle.
  - New requests are ignored, not queued; the initiator must wait for bus_full.
- Entry into RESPOND (one edge, performed in this order):
  - bus_full=1.
  - Write: merge latched data into the addressed word, per sel bit.
  - Read: data_out <= RAM word, pre-write contents; a read never coincides with a write.
- RESPOND:
  - Lasts one cycle, then goes to IDLE.
  - bus_full, err and busy drop at that edge.
  - The earliest next accept is the first IDLE edge. Back-to-back request spacing is LATENCY+2 cycles.
- Timing rule: bus_full is high exactly during the cycle that begins LATENCY cycles after the accepting edge.
- data_out behaviour:
  - Holds the last read result until the next read response.
  - Writes do not change data_out.
- Address decode:
  - offset = address_in - BASE_ADDR, computed modulo 2^32.
  - Word index = offset[31:2].
  - Error if offset[1:0] != 0 or offset[31:2] >= DEPTH. An out-of-range address does not wrap.
- Error response:
  - Full handshake: bus_full=1, err=1.
  - Write is dropped; read returns data_out=32'h0.
- sel=4'b0000 on a write: a legal no-op with a normal response.
- Reads ignore sel.

Decomposition:
- Package mem_bus_pkg:
  - typedef enum state_t {IDLE, BUSY, RESPOND}.
  - typedef enum op_t {OP_READ, OP_WRITE}.
  - Constant ERR_RDATA = 32'h0.
- Sub-module mem_bus_ram:
  - Single-port synchronous RAM with DEPTH words, 32-bit wide.
  - Per-byte write enables, registered read.
  - Instantiated once; the FSM and address decode stay in the top level.

Test Plan:
- Reset: rst high for 2 cycles, then low -> data_out=0, bus_full=0, busy=0, err=0; no bus_full for 10 idle cycles.
- Write then read, LATENCY=2:
  - Write addr 0x8 data 0x0000_0001 sel=4'hF -> bus_full in exactly the 3rd cycle after the accept edge, err=0.
  - Read addr 0x8 -> data_out=0x0000_0001 with bus_full.
- Byte enables:
  - Write 0x10 data 0xAABB_CCDD sel=4'hF, then write 0x10 data 0x1122_3344 sel=4'b0101.
  - Read 0x10 -> 0xAA22_CC44.
- Errors:
  - Read addr 0x2 (misaligned) -> bus_full=1, err=1, data_out=0.
  - Write addr 4*DEPTH, then read 0x0 -> err on the write; word 0 unchanged.
- Busy ignore / simultaneous:
  - Read 0x8, then pulse write_en to 0x8 while busy -> write ignored; later read of 0x8 returns the old value.
  - read_en=write_en=1 at addr 0x8 data 0x5 -> write committed, err=1; later read returns 0x5.
- Reset mid-operation:
  - Issue write 0xC data 0xDEAD_BEEF, assert rst during BUSY -> no bus_full.
  - Read 0xC after reset -> prior value, not 0xDEAD_BEEF.

Source files
------------

// File: rtl/mem_bus_pkg.sv
// Shared types and constants for the cpu_core memory-bus responder.
package mem_bus_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BUSY    = 2'd1,
        RESPOND = 2'd2
    } state_t;

    typedef enum logic {
        OP_READ  = 1'b0,
        OP_WRITE = 1'b1
    } op_t;

    localparam logic [31:0] ERR_RDATA = 32'h0;

endpackage

// File: rtl/mem_bus_ram.sv
// Single-port word RAM with per-byte write enables and a registered read port.
module mem_bus_ram
    import mem_bus_pkg::*;
#(
    parameter int unsigned DEPTH = 256,
    parameter int unsigned AW    = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [AW-1:0] addr,
    input  logic [31:0]   wdata,
    input  logic [3:0]    be,
    input  logic          we,
    input  logic          re,
    input  logic          clr,
    output logic [31:0]   rdata
);

    logic [31:0] mem [DEPTH];

    // Storage is never reset; contents survive rst.
    always_ff @(posedge clk) begin
        if (we) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) begin
                    mem[addr][8*i +: 8] <= wdata[8*i +: 8];
                end
            end
        end
    end

    // Read register holds its value until the next read or clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdata <= '0;
        end else if (clr) begin
            rdata <= ERR_RDATA;
        end else if (re) begin
            rdata <= mem[addr];
        end
    end

endmodule

// File: rtl/mem_bus_responder.sv
// Memory-side bus responder: accepts one request at a time and answers with a
// one-cycle bus_full strobe LATENCY cycles after the accepting edge.
module mem_bus_responder
    import mem_bus_pkg::*;
#(
    parameter int unsigned DEPTH     = 256,
    parameter int unsigned LATENCY   = 2,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] address_in,
    input  logic [31:0] data_in,
    input  logic        read_en,
    input  logic        write_en,
    input  logic [3:0]  sel,
    output logic [31:0] data_out,
    output logic        bus_full,
    output logic        busy,
    output logic        err
);

    localparam int unsigned AW    = $clog2(DEPTH);
    localparam int unsigned CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    state_t             state, state_next;
    logic [CNT_W-1:0]   cnt, cnt_next;
    logic               busy_next, full_next, err_next;
    logic               accept;
    logic               ram_we, ram_re, ram_clr;

    logic [31:0]        offset;
    logic               addr_bad;

    logic [AW-1:0]      req_idx;
    logic [31:0]        req_data;
    logic [3:0]         req_sel;
    op_t                req_op;
    logic               req_bad;
    logic               req_both;

    assign offset   = address_in - BASE_ADDR;
    assign addr_bad = (offset[1:0] != 2'b00) || (offset[31:2] >= 30'(DEPTH));

    // Request capture on the accepting edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            req_idx  <= '0;
            req_data <= '0;
            req_sel  <= '0;
            req_op   <= OP_READ;
            req_bad  <= 1'b0;
            req_both <= 1'b0;
        end else if (accept) begin
            req_idx  <= offset[AW+1:2];
            req_data <= data_in;
            req_sel  <= sel;
            req_op   <= write_en ? OP_WRITE : OP_READ;
            req_bad  <= addr_bad;
            req_both <= read_en && write_en;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            cnt      <= '0;
            busy     <= 1'b0;
            bus_full <= 1'b0;
            err      <= 1'b0;
        end else begin
            state    <= state_next;
            cnt      <= cnt_next;
            busy     <= busy_next;
            bus_full <= full_next;
            err      <= err_next;
        end
    end

    // RAM access is issued in the last BUSY cycle so it lands on the RESPOND edge.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        busy_next  = busy;
        full_next  = 1'b0;
        err_next   = 1'b0;
        accept     = 1'b0;
        ram_we     = 1'b0;
        ram_re     = 1'b0;
        ram_clr    = 1'b0;
        case (state)
            IDLE: begin
                busy_next = 1'b0;
                if (read_en || write_en) begin
                    accept     = 1'b1;
                    state_next = BUSY;
                    cnt_next   = CNT_W'(LATENCY - 1);
                    busy_next  = 1'b1;
                end
            end
            BUSY: begin
                if (cnt == '0) begin
                    state_next = RESPOND;
                    full_next  = 1'b1;
                    err_next   = req_bad || req_both;
                    if (req_op == OP_WRITE) begin
                        ram_we = !req_bad;
                    end else if (req_bad) begin
                        ram_clr = 1'b1;
                    end else begin
                        ram_re = 1'b1;
                    end
                end else begin
                    cnt_next = cnt - CNT_W'(1);
                end
            end
            RESPOND: begin
                state_next = IDLE;
                busy_next  = 1'b0;
            end
            default: begin
                state_next = IDLE;
                busy_next  = 1'b0;
            end
        endcase
    end

    mem_bus_ram #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_ram (
        .clk   (clk),
        .rst   (rst),
        .addr  (req_idx),
        .wdata (req_data),
        .be    (req_sel),
        .we    (ram_we),
        .re    (ram_re),
        .clr   (ram_clr),
        .rdata (data_out)
    );

endmodule

// File: tb/tb_mem_bus_responder.sv
// Directed bench for mem_bus_responder (DEPTH=256, LATENCY=2, BASE_ADDR=0).
module tb_mem_bus_responder;

    logic        clk;
    logic        rst;
    logic [31:0] address_in;
    logic [31:0] data_in;
    logic        read_en;
    logic        write_en;
    logic [3:0]  sel;
    logic [31:0] data_out;
    logic        bus_full;
    logic        busy;
    logic        err;

    int n_checks = 0;
    int n_fail   = 0;

    mem_bus_responder #(
        .DEPTH     (256),
        .LATENCY   (2),
        .BASE_ADDR (32'h0000_0000)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .address_in (address_in),
        .data_in    (data_in),
        .read_en    (read_en),
        .write_en   (write_en),
        .sel        (sel),
        .data_out   (data_out),
        .bus_full   (bus_full),
        .busy       (busy),
        .err        (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drives one request from a negedge; returns the cycle (1-based after the
    // accept edge) in which bus_full was seen, 0 on timeout.
    task automatic do_req(input logic rd, input logic wr, input logic [31:0] a,
                          input logic [31:0] d, input logic [3:0] s,
                          output int k, output logic [31:0] dout, output logic e,
                          output logic b1, output logic full_after);
        read_en    = rd;
        write_en   = wr;
        address_in = a;
        data_in    = d;
        sel        = s;
        k    = 0;
        dout = '0;
        e    = 1'b0;
        b1   = 1'b0;
        @(posedge clk);
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            if (i == 1) begin
                b1       = busy;
                read_en  = 1'b0;
                write_en = 1'b0;
            end
            if (bus_full) begin
                k    = i;
                dout = data_out;
                e    = err;
                break;
            end
        end
        @(negedge clk);
        full_after = bus_full;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_checks++;
        if ({data_out, bus_full, busy, err} !== 35'h0) begin
            n_fail++;
            $display("FAIL reset_outputs: got data_out=%h full=%b busy=%b err=%b, want all zero",
                     data_out, bus_full, busy, err);
        end
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            n_checks++;
            if (bus_full !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_idle_full: cycle %0d got bus_full=%b want 0", i, bus_full);
            end
        end
    endtask

    task automatic test_write_read();
        int k; logic [31:0] d; logic e, b1, fa;
        do_req(1'b0, 1'b1, 32'h8, 32'h0000_0001, 4'hF, k, d, e, b1, fa);
        n_checks++;
        if (k !== 3 || e !== 1'b0) begin
            n_fail++;
            $display("FAIL wr8_timing: got cycle=%0d err=%b want cycle=3 err=0", k, e);
        end
        n_checks++;
        if (b1 !== 1'b1) begin
            n_fail++;
            $display("FAIL wr8_busy: got busy=%b want 1", b1);
        end
        n_checks++;
        if (fa !== 1'b0) begin
            n_fail++;
            $display("FAIL wr8_strobe_drop: got bus_full=%b want 0", fa);
        end
        do_req(1'b1, 1'b0, 32'h8, 32'h0, 4'h0, k, d, e, b1, fa);
        n_checks++;
        if (k !== 3 || d !== 32'h0000_0001 || e !== 1'b0) begin
            n_fail++;
            $display("FAIL rd8: got cycle=%0d data=%h err=%b want cycle=3 data=00000001 err=0", k, d, e);
        end
        // Last valid word, then confirm data_out is untouched by a write.
        do_req(1'b0, 1'b1, 32'h3FC, 32'h0BAD_F00D, 4'hF, k, d, e, b1, fa);
        n_checks++;
        if (k !== 3 || e !== 1'b0 || data_out !== 32'h0000_0001) begin
            n_fail++;
            $display("FAIL wr_last: got cycle=%0d err=%b data_out=%h want cycle=3 err=0 data_out=00000001",
                     k, e, data_out);
        end
        do_req(1'b1, 1'b0, 32'h3FC, 32'h0, 4'h0, k, d, e, b1, fa);
        n_checks++;
        if (k !== 3 || d !== 32'h0BAD_F00D || e !== 1'b0) begin
            n_fail++;
            $display("FAIL rd_last: got cycle=%0d data=%h err=%b want cycle=3 data=0badf00d err=0", k, d, e);
        end
    endtask

    task automatic test_byte_enables();
        int k; logic [31:0] d; logic e, b1, fa;
        do_req(1'b0, 1'b1, 32'h10, 32'hAABB_CCDD, 4'hF, k, d, e, b1, fa);
        do_req(1'b0, 1'b1, 32'h10, 32'h1122_3344, 4'b0101, k, d, e, b1, fa);
        do_req(1'b1, 1'b0, 32'h10, 32'h0, 4'h0, k, d, e, b1, fa);
        n_checks++;
        if (k !== 3 || d !== 32'hAA22_CC44) begin
            n_fail++;
            $display("FAIL byte_merge: got cycle=%0d data=%h want cycle=3 data=aa22cc44", k, d);
        end
        do_req(1'b0, 1'b1, 32'h10, 32'hFFFF_FFFF, 4'b0000, k, d, e, b1, fa);
        n_checks++;
        if (k !== 3 || e !== 1'b0) begin
            n_fail++;
            $display("FAIL sel0_resp: got cycle=%0d err=%b want cycle=3 err=0", k, e);
        end
        do_req(1'b1, 1'b0, 32'h10, 32'h0, 4'h0, k, d, e, b1, fa);
        n_checks++;
        if (d !== 32'hAA22_CC44) begin
            n_fail++;
            $display("FAIL sel0_noop: got data=%h want aa22cc44", d);
        end
    endtask

    task automatic test_errors();
        int k; logic [31:0] d; logic e, b1, fa;
        do_req(1'b0, 1'b1, 32'h0, 32'h1234_5678, 4'hF, k, d, e, b1, fa);
        do_req(1'b1, 1'b0, 32'h2, 32'h0, 4'hF, k, d, e, b1, fa);
        n_checks++;
        if (k !== 3 || e !== 1'b1 || d !== 32'h0) begin
            n_fail++;
            $display("FAIL rd_misaligned: got cycle=%0d err=%b data=%h want cycle=3 err=1 data=00000000", k, e, d);
        end
        n_checks++;
        if (err !== 1'b0) begin
            n_fail++;
            $display("FAIL err_drop: got err=%b want 0", err);
        end
        do_req(1'b0, 1'b1, 32'h400, 32'hFFFF_FFFF, 4'hF, k, d, e, b1, fa);
        n_checks++;
        if (k !== 3 || e !== 1'b1) begin
            n_fail++;
            $display("FAIL wr_oob: got cycle=%0d err=%b want cycle=3 err=1", k, e);
        end
        do_req(1'b1, 1'b0, 32'h0, 32'h0, 4'h0, k, d, e, b1, fa);
        n_checks++;
        if (d !== 32'h1234_5678 || e !== 1'b0) begin
            n_fail++;
            $display("FAIL oob_no_wrap: got data=%h err=%b want 12345678 err=0", d, e);
        end
    endtask

    task automatic test_busy_ignore();
        int k; logic [31:0] d; logic e, b1, fa;
        // Read 0x8, then pulse a write during BUSY.
        read_en = 1'b1; write_en = 1'b0; address_in = 32'h8; sel = 4'h0;
        @(posedge clk);
        @(negedge clk);
        read_en = 1'b0; write_en = 1'b1; data_in = 32'h0000_0099; sel = 4'hF;
        @(negedge clk);
        write_en = 1'b0;
        k = 0;
        for (int i = 3; i <= 10; i++) begin
            if (bus_full) begin
                k = i - 1;
                break;
            end
            @(negedge clk);
        end
        n_checks++;
        if (k !== 3 || data_out !== 32'h0000_0001) begin
            n_fail++;
            $display("FAIL busy_read: got cycle=%0d data=%h want cycle=3 data=00000001", k, data_out);
        end
        @(negedge clk);
        do_req(1'b1, 1'b0, 32'h8, 32'h0, 4'h0, k, d, e, b1, fa);
        n_checks++;
        if (d !== 32'h0000_0001) begin
            n_fail++;
            $display("FAIL busy_ignore: got data=%h want 00000001", d);
        end
        do_req(1'b1, 1'b1, 32'h8, 32'h0000_0005, 4'hF, k, d, e, b1, fa);
        n_checks++;
        if (k !== 3 || e !== 1'b1) begin
            n_fail++;
            $display("FAIL both_en: got cycle=%0d err=%b want cycle=3 err=1", k, e);
        end
        do_req(1'b1, 1'b0, 32'h8, 32'h0, 4'h0, k, d, e, b1, fa);
        n_checks++;
        if (d !== 32'h0000_0005 || e !== 1'b0) begin
            n_fail++;
            $display("FAIL both_commit: got data=%h err=%b want 00000005 err=0", d, e);
        end
    endtask

    task automatic test_reset_mid();
        int k; logic [31:0] d; logic e, b1, fa;
        do_req(1'b0, 1'b1, 32'hC, 32'hCAFE_0001, 4'hF, k, d, e, b1, fa);
        read_en = 1'b0; write_en = 1'b1; address_in = 32'hC; data_in = 32'hDEAD_BEEF; sel = 4'hF;
        @(posedge clk);
        @(negedge clk);
        write_en = 1'b0;
        rst = 1'b1;
        #1;
        n_checks++;
        if (busy !== 1'b0 || data_out !== 32'h0) begin
            n_fail++;
            $display("FAIL mid_reset_async: got busy=%b data_out=%h want busy=0 data_out=00000000", busy, data_out);
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_checks++;
            if (bus_full !== 1'b0) begin
                n_fail++;
                $display("FAIL mid_reset_full: cycle %0d got bus_full=%b want 0", i, bus_full);
            end
        end
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            n_checks++;
            if (bus_full !== 1'b0) begin
                n_fail++;
                $display("FAIL post_reset_full: cycle %0d got bus_full=%b want 0", i, bus_full);
            end
        end
        do_req(1'b1, 1'b0, 32'hC, 32'h0, 4'h0, k, d, e, b1, fa);
        n_checks++;
        if (k !== 3 || d !== 32'hCAFE_0001) begin
            n_fail++;
            $display("FAIL abort_no_write: got cycle=%0d data=%h want cycle=3 data=cafe0001", k, d);
        end
    endtask

    initial begin
        rst        = 1'b1;
        address_in = '0;
        data_in    = '0;
        read_en    = 1'b0;
        write_en   = 1'b0;
        sel        = '0;
        test_reset();
        test_write_read();
        test_byte_enables();
        test_errors();
        test_busy_ignore();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1);
    end

endmodule
